// File: rtl/mem_prog_ws_pkg.sv
// mem_prog_ws_pkg: shared FSM state encoding and counter width for the program memory
//   mpw_state_t : IDLE / WAIT / RESP, 2-bit encoding
//   MPW_CNT_W   : wait-state counter width (WAIT_CYC range 0..15)
package mem_prog_ws_pkg;
   typedef enum logic [1:0] {
      MPW_IDLE = 2'd0,
      MPW_WAIT = 2'd1,
      MPW_RESP = 2'd2
   } mpw_state_t;
   localparam int MPW_CNT_W = 4;
endpackage

// File: rtl/mem_prog_ws_ctl.sv
// mem_prog_ws_ctl: request/response FSM, wait-state counter and handshake outputs
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid             fetch request
//   i_rsp_ready             response consumer ready
//   i_flush                 abandon in-flight request
//   o_req_ready             request can be accepted this cycle
//   o_accept                request accepted on this edge
//   o_capture               read data must be captured on this edge (entering RESP)
//   o_rsp_valid             registered response valid
module mem_prog_ws_ctl
   import mem_prog_ws_pkg::*;
#(
   parameter int WAIT_CYC = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_valid,
   input  logic i_rsp_ready,
   input  logic i_flush,
   output logic o_req_ready,
   output logic o_accept,
   output logic o_capture,
   output logic o_rsp_valid
);
   localparam logic [MPW_CNT_W-1:0] CNT_LOAD = MPW_CNT_W'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
   mpw_state_t r_state;
   logic [MPW_CNT_W-1:0] r_cnt;
   logic r_rsp_valid;
   assign o_req_ready = (r_state == MPW_IDLE) & ~i_flush & ~i_rst;
   assign o_accept    = o_req_ready & i_req_valid;
   // with no wait states the accept edge is also the capture edge
   assign o_capture   = (WAIT_CYC == 0) ? o_accept
                      : (r_state == MPW_WAIT) & (r_cnt == '0) & ~i_flush & ~i_rst;
   assign o_rsp_valid = r_rsp_valid;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_state     <= MPW_IDLE;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            MPW_IDLE: if (i_req_valid) begin
               r_state     <= (WAIT_CYC == 0) ? MPW_RESP : MPW_WAIT;
               r_cnt       <= CNT_LOAD;
               r_rsp_valid <= (WAIT_CYC == 0);
            end
            MPW_WAIT: if (r_cnt == '0) begin
               r_state     <= MPW_RESP;
               r_rsp_valid <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            MPW_RESP: if (i_rsp_ready) begin
               r_state     <= MPW_IDLE;
               r_rsp_valid <= 1'b0;
            end
            default: r_state <= MPW_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/mem_prog_ws.sv
// mem_prog_ws: wait-state program memory with request/response handshake and loader port
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_req_valid, i_req_addr          fetch request, word address of first word
//   o_req_ready                      request accepted when valid & ready
//   o_rsp_valid, i_rsp_ready         response handshake
//   o_rsp_data                       word i = mem[addr+i] at bits [32i+31:32i]
//   o_rsp_err                        some fetched word lies beyond DATA_DEP-1
//   i_flush                          abandon in-flight request
//   i_ld_en, i_ld_addr, i_ld_data    loader write port, active in every state
module mem_prog_ws
   import mem_prog_ws_pkg::*;
#(
   parameter int DATA_DEP    = 512,
   parameter int ADDR_WID    = 30,
   parameter int FETCH_WORDS = 1,
   parameter int WAIT_CYC    = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_req_valid,
   input  logic [ADDR_WID-1:0]      i_req_addr,
   output logic                     o_req_ready,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [32*FETCH_WORDS-1:0] o_rsp_data,
   output logic                     o_rsp_err,
   input  logic                     i_flush,
   input  logic                     i_ld_en,
   input  logic [ADDR_WID-1:0]      i_ld_addr,
   input  logic [31:0]              i_ld_data
);
   localparam int MEM_AW = $clog2(DATA_DEP);
   localparam logic [ADDR_WID:0] DEP = (ADDR_WID + 1)'(DATA_DEP);
   logic [31:0] r_mem [DATA_DEP];
   logic [ADDR_WID-1:0] r_addr;
   logic [32*FETCH_WORDS-1:0] r_rsp_data;
   logic r_rsp_err;
   logic w_accept, w_capture;
   logic [ADDR_WID-1:0] w_addr;
   logic [FETCH_WORDS-1:0] w_oor;
   logic [32*FETCH_WORDS-1:0] w_data;
   mem_prog_ws_ctl #(.WAIT_CYC(WAIT_CYC)) u_ctl (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .i_rsp_ready (i_rsp_ready),
      .i_flush     (i_flush),
      .o_req_ready (o_req_ready),
      .o_accept    (w_accept),
      .o_capture   (w_capture),
      .o_rsp_valid (o_rsp_valid)
   );
   // zero wait states capture on the accept edge, before r_addr could be loaded
   assign w_addr = (WAIT_CYC == 0) ? i_req_addr : r_addr;
   // one extra address bit so addr+i never wraps back into range
   for (genvar i = 0; i < FETCH_WORDS; i++) begin : g_word
      logic [ADDR_WID:0] w_a;
      assign w_a = {1'b0, w_addr} + (ADDR_WID + 1)'(i);
      assign w_oor[i] = w_a >= DEP;
      assign w_data[32*i +: 32] = w_oor[i] ? 32'h0 : r_mem[w_a[MEM_AW-1:0]];
   end
   // loader ignores reset; the read above sees the pre-write word on a shared edge
   always_ff @(posedge i_clk) begin
      if (i_ld_en && ({1'b0, i_ld_addr} < DEP)) r_mem[i_ld_addr[MEM_AW-1:0]] <= i_ld_data;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else if (w_capture) begin
         r_rsp_data <= w_data;
         r_rsp_err  <= |w_oor;
      end
      if (w_accept) r_addr <= i_req_addr;
   end
   assign o_rsp_data = r_rsp_data;
   assign o_rsp_err  = r_rsp_err;
endmodule

// File: tb/tb_mem_prog_ws.sv
// tb_mem_prog_ws: directed and randomized checks of two mem_prog_ws configurations against an array model
module tb_mem_prog_ws;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, ld_en, sel, req_valid, rsp_ready, flush, seen;
   logic [29:0] ld_addr, req_addr;
   logic [31:0] ld_data;
   logic a_req_ready, a_rsp_valid, a_rsp_err, b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] a_rsp_data;
   logic [127:0] b_rsp_data;
   logic cur_ready, cur_valid, cur_err;
   logic [127:0] cur_data;
   logic [31:0] m [512];
   int checks = 0, errors = 0;
   // sel=0 drives the WAIT_CYC=2 single-word instance, sel=1 the zero-wait four-word one
   mem_prog_ws #(.DATA_DEP(512), .ADDR_WID(30), .FETCH_WORDS(1), .WAIT_CYC(2)) u_a (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid & ~sel), .i_req_addr(req_addr),
      .o_req_ready(a_req_ready), .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(a_rsp_data), .o_rsp_err(a_rsp_err), .i_flush(flush & ~sel),
      .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
   mem_prog_ws #(.DATA_DEP(512), .ADDR_WID(30), .FETCH_WORDS(4), .WAIT_CYC(0)) u_b (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid & sel), .i_req_addr(req_addr),
      .o_req_ready(b_req_ready), .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(b_rsp_data), .o_rsp_err(b_rsp_err), .i_flush(flush & sel),
      .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
   assign cur_ready = sel ? b_req_ready : a_req_ready;
   assign cur_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign cur_err   = sel ? b_rsp_err : a_rsp_err;
   assign cur_data  = sel ? b_rsp_data : {96'h0, a_rsp_data};
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [127:0] exp_data(input longint a, input int fw);
      logic [127:0] d = '0;
      for (int i = 0; i < fw; i++) if (a + i < 512) d[32*i +: 32] = m[int'(a + i)];
      return d;
   endfunction
   task automatic txn(input logic s, input longint addr, input int hold, input bit ld);
      logic [127:0] ed;
      logic ee;
      logic [31:0] nd;
      int w, fw, lat;
      sel = s;
      w = s ? 0 : 2;
      fw = s ? 4 : 1;
      ed = exp_data(addr, fw);
      ee = (addr + fw - 1 >= 512);
      nd = $urandom;
      req_valid = 1'b1;
      req_addr = addr[29:0];
      rsp_ready = 1'b0;
      if (ld && w == 0) begin ld_en = 1'b1; ld_addr = addr[29:0]; ld_data = nd; end
      #1 chk("req_ready idle", 128'(cur_ready), 128'(1));
      @(posedge clk); #2;
      req_valid = 1'b0;
      req_addr = 30'($urandom);
      ld_en = 1'b0;
      lat = 1;
      while (!cur_valid && lat < 20) begin
         if (ld && lat == w) begin ld_en = 1'b1; ld_addr = addr[29:0]; ld_data = nd; end
         @(posedge clk); #2;
         ld_en = 1'b0;
         lat++;
      end
      if (ld && addr < 512) m[int'(addr)] = nd;
      chk("latency", 128'(lat), 128'(w + 1));
      chk("rsp_data", cur_data, ed);
      chk("rsp_err", 128'(cur_err), 128'(ee));
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1;
         req_addr = 30'($urandom_range(0, 511));
         #1 chk("req_ready in RESP", 128'(cur_ready), 128'(0));
         @(posedge clk); #2;
         chk("hold valid", 128'(cur_valid), 128'(1));
         chk("hold data", cur_data, ed);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #2;
      rsp_ready = 1'b0;
      chk("valid after consume", 128'(cur_valid), 128'(0));
      #1 chk("req_ready after consume", 128'(cur_ready), 128'(1));
   endtask
   initial begin
      longint addr;
      rst = 1'b1; ld_en = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
      ld_addr = '0; ld_data = '0; req_addr = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset a_rsp_valid", 128'(a_rsp_valid), 128'(0));
      chk("reset a_rsp_data", 128'(a_rsp_data), 128'(0));
      chk("reset a_rsp_err", 128'(a_rsp_err), 128'(0));
      chk("reset b_rsp_valid", 128'(b_rsp_valid), 128'(0));
      chk("reset b_rsp_data", b_rsp_data, 128'(0));
      chk("reset a_req_ready", 128'(a_req_ready), 128'(0));
      rst = 1'b0;
      #1 chk("post-reset a_req_ready", 128'(a_req_ready), 128'(1));
      chk("post-reset b_req_ready", 128'(b_req_ready), 128'(1));
      for (int k = 0; k < 512; k++) begin
         m[k] = (k == 5) ? 32'h0050_0093 : $urandom;
         ld_en = 1'b1; ld_addr = 30'(k); ld_data = m[k];
         @(posedge clk); #2;
      end
      ld_addr = 30'd512; ld_data = ~m[0];
      @(posedge clk); #2;
      ld_addr = 30'd515; ld_data = ~m[3];
      @(posedge clk); #2;
      ld_en = 1'b0;
      txn(1'b0, 5, 0, 0);
      txn(1'b1, 510, 0, 0);
      txn(1'b1, 0, 0, 0);
      txn(1'b1, 30'h3FFF_FFFE, 0, 0);
      txn(1'b0, 3, 5, 0);
      sel = 1'b0; req_valid = 1'b1; req_addr = 30'd40;
      @(posedge clk); #2;
      req_valid = 1'b0; flush = 1'b1;
      #1 chk("req_ready during flush", 128'(cur_ready), 128'(0));
      @(posedge clk); #2;
      flush = 1'b0;
      #1 chk("req_ready after wait flush", 128'(cur_ready), 128'(1));
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #2; seen |= cur_valid; end
      chk("no rsp after wait flush", 128'(seen), 128'(0));
      txn(1'b0, 7, 0, 0);
      sel = 1'b1; req_valid = 1'b1; req_addr = 30'd100;
      @(posedge clk); #2;
      req_valid = 1'b0;
      chk("b valid before resp flush", 128'(cur_valid), 128'(1));
      flush = 1'b1;
      @(posedge clk); #2;
      flush = 1'b0;
      chk("valid after resp flush", 128'(cur_valid), 128'(0));
      #1 chk("req_ready after resp flush", 128'(cur_ready), 128'(1));
      flush = 1'b1; req_valid = 1'b1; req_addr = 30'd200;
      #1 chk("req_ready flush in idle", 128'(cur_ready), 128'(0));
      @(posedge clk); #2;
      flush = 1'b0; req_valid = 1'b0;
      chk("no accept under flush", 128'(cur_valid), 128'(0));
      txn(1'b0, 9, 0, 1);
      txn(1'b0, 9, 0, 0);
      txn(1'b1, 9, 0, 1);
      txn(1'b1, 8, 0, 0);
      txn(1'b0, 5, 0, 0);
      sel = 1'b0; req_valid = 1'b1; req_addr = 30'd12;
      @(posedge clk); #2;
      req_valid = 1'b0; rst = 1'b1;
      ld_en = 1'b1; ld_addr = 30'd20; ld_data = $urandom; m[20] = ld_data;
      @(posedge clk); #2;
      rst = 1'b0; ld_en = 1'b0;
      chk("valid after rst in wait", 128'(a_rsp_valid), 128'(0));
      chk("data after rst in wait", 128'(a_rsp_data), 128'(0));
      chk("err after rst in wait", 128'(a_rsp_err), 128'(0));
      #1 chk("req_ready after rst", 128'(cur_ready), 128'(1));
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #2; seen |= a_rsp_valid; end
      chk("no rsp after rst", 128'(seen), 128'(0));
      txn(1'b0, 20, 0, 0);
      repeat (24) begin
         case ($urandom_range(0, 3))
            0: addr = $urandom_range(500, 520);
            1: addr = longint'($urandom) & 64'h3FFF_FFFF;
            default: addr = $urandom_range(0, 511);
         endcase
         txn(1'($urandom_range(0, 1)), addr, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
